// File: rtl/seg_scan_if.sv
// Bundle between a value source and the seven-segment scan driver.
// The master side loads hex values; the slave side drives the display pins.
interface seg_scan_if;
   logic        load;
   logic [15:0] value;
   logic [3:0]  dp_in;
   logic        lzb_en;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  anode;
   logic        frame_done;
   logic        upd_pend;

   modport master (
      output load, value, dp_in, lzb_en,
      input  seg, dp, anode, frame_done, upd_pend
   );

   modport slave (
      input  load, value, dp_in, lzb_en,
      output seg, dp, anode, frame_done, upd_pend
   );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// New values are committed only at frame boundaries so a frame never mixes two values.
module seg_scan_driver #(
   parameter int REFRESH_DIV = 100000,
   parameter int BLANK_CYC   = 2
) (
   input  logic       clk,
   input  logic       rst,
   seg_scan_if.slave  bus
);

   localparam int                CNT_W   = $clog2(REFRESH_DIV);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0]  BLANK_N = CNT_W'(BLANK_CYC);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       dig_q, dig_d;
   logic [15:0]      pend_val_q, shown_val_q;
   logic [3:0]       pend_dp_q, shown_dp_q;
   logic             upd_pend_q;
   logic [3:0]       anode_q, anode_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;
   logic             frame_done_q;
   logic             fb;
   logic [3:0]       nib;
   logic [3:0]       lead_zero;
   logic             lz_blank;

   function automatic logic [6:0] hex7(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   // lead_zero[i]: digit i and every digit above it are zero; digit0 is never blanked
   always_comb begin
      lead_zero[3] = (shown_val_q[15:12] == 4'h0);
      lead_zero[2] = lead_zero[3] && (shown_val_q[11:8] == 4'h0);
      lead_zero[1] = lead_zero[2] && (shown_val_q[7:4] == 4'h0);
      lead_zero[0] = 1'b0;
   end

   always_comb begin
      fb       = (dig_q == 2'd3) && (cnt_q == CNT_MAX);
      cnt_d    = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
      dig_d    = (cnt_q == CNT_MAX) ? dig_q + 2'd1 : dig_q;
      nib      = shown_val_q[{dig_q, 2'b00} +: 4];
      lz_blank = bus.lzb_en && lead_zero[dig_q];
      anode_d  = 4'b1111;
      seg_d    = 7'b1111111;
      dp_d     = 1'b1;
      // Start-of-slot blank window keeps the previous digit from ghosting
      if (cnt_q >= BLANK_N) begin
         dp_d = ~shown_dp_q[dig_q];
         if (!lz_blank) begin
            anode_d = ~(4'b0001 << dig_q);
            seg_d   = hex7(nib);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q        <= '0;
         dig_q        <= 2'd0;
         pend_val_q   <= 16'h0000;
         pend_dp_q    <= 4'h0;
         shown_val_q  <= 16'h0000;
         shown_dp_q   <= 4'h0;
         upd_pend_q   <= 1'b0;
         anode_q      <= 4'b1111;
         seg_q        <= 7'b1111111;
         dp_q         <= 1'b1;
         frame_done_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         dig_q <= dig_d;
         if (bus.load) begin
            pend_val_q <= bus.value;
            pend_dp_q  <= bus.dp_in;
         end
         // A load landing on the boundary bypasses the pending register
         if (fb) begin
            if (bus.load) begin
               shown_val_q <= bus.value;
               shown_dp_q  <= bus.dp_in;
            end else if (upd_pend_q) begin
               shown_val_q <= pend_val_q;
               shown_dp_q  <= pend_dp_q;
            end
            upd_pend_q <= 1'b0;
         end else if (bus.load) begin
            upd_pend_q <= 1'b1;
         end
         anode_q      <= anode_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         frame_done_q <= fb;
      end
   end

   assign bus.anode      = anode_q;
   assign bus.seg        = seg_q;
   assign bus.dp         = dp_q;
   assign bus.frame_done = frame_done_q;
   assign bus.upd_pend   = upd_pend_q;

endmodule
